// File: rtl/datapath_pkg.sv
// Shared encodings for the datapath sequencer: op and register codes, bus-select bit
// positions, FSM state encoding and the memory wait timeout.
package datapath_pkg;

  localparam logic [1:0] OP_MOVE    = 2'b00;
  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_STORE   = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] REG_R0      = 2'd0;
  localparam logic [1:0] REG_R1      = 2'd1;
  localparam logic [1:0] REG_MDR     = 2'd2;
  localparam logic [1:0] REG_ILLEGAL = 2'd3;

  localparam int ENC_WIDTH   = 32;
  localparam int ENC_R0_BIT  = 0;
  localparam int ENC_R1_BIT  = 1;
  localparam int ENC_MDR_BIT = 2;

  localparam int              TIMER_WIDTH   = 8;
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    MEM_WAIT,
    LOAD_MDR,
    XFER,
    DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] src;
    logic [1:0] dst;
  } cmd_t;

  function automatic logic [ENC_WIDTH-1:0] enc_select(input logic [1:0] code);
    logic [ENC_WIDTH-1:0] v;
    v = '0;
    case (code)
      REG_R0:  v[ENC_R0_BIT]  = 1'b1;
      REG_R1:  v[ENC_R1_BIT]  = 1'b1;
      REG_MDR: v[ENC_MDR_BIT] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  // src only matters for MOVE/STORE, dst only for MOVE/LOAD.
  function automatic logic cmd_illegal(input cmd_t c);
    logic src_used;
    logic dst_used;
    src_used = (c.op == OP_MOVE) || (c.op == OP_STORE);
    dst_used = (c.op == OP_MOVE) || (c.op == OP_LOAD);
    return (c.op == OP_ILLEGAL) ||
           (src_used && (c.src == REG_ILLEGAL)) ||
           (dst_used && (c.dst == REG_ILLEGAL));
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory wait counter: cleared on entry to a wait, counts while enabled and flags
// the last permitted wait cycle.
module wait_timer (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  import datapath_pkg::*;

  logic [TIMER_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == TIMEOUT_LIMIT);

endmodule

// File: rtl/datapath_sequencer.sv
// Moore sequencer driving register load enables, bus source select and a memory
// handshake for MOVE / LOAD / STORE commands.
module datapath_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_src,
  input  logic [1:0]  cmd_dst,
  output logic [31:0] enc_out,
  output logic        R0in,
  output logic        R1in,
  output logic        MDRin,
  output logic        readMDR,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);
  import datapath_pkg::*;

  state_t state;
  state_t next_state;
  cmd_t   cmd_q;
  cmd_t   cmd_in;
  logic   err_q;
  logic   err_next;
  logic   accept;
  logic   timer_clear;
  logic   timer_en;
  logic   timer_expired;

  assign cmd_in      = {cmd_op, cmd_src, cmd_dst};
  assign accept      = cmd_valid && cmd_ready;
  assign timer_en    = (state == MEM_WAIT);
  assign timer_clear = clr || ((next_state == MEM_WAIT) && (state != MEM_WAIT));

  wait_timer u_wait_timer (
    .clk     (clk),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cmd_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= next_state;
      err_q <= err_next;
      if (accept) begin
        cmd_q <= cmd_in;
      end
    end
  end

  // Outputs are forced low while clr is held so nothing is requested during reset.
  always_comb begin
    next_state = state;
    err_next   = err_q;
    cmd_ready  = 1'b0;
    enc_out    = '0;
    R0in       = 1'b0;
    R1in       = 1'b0;
    MDRin      = 1'b0;
    readMDR    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state)
      IDLE: begin
        cmd_ready = !clr;
        if (cmd_valid && !clr) begin
          if (cmd_illegal(cmd_in)) begin
            next_state = DONE;
            err_next   = 1'b1;
          end else begin
            err_next   = 1'b0;
            next_state = (cmd_in.op == OP_LOAD) ? MEM_WAIT : XFER;
          end
        end
      end
      MEM_WAIT: begin
        mem_req = !clr;
        mem_we  = !clr && (cmd_q.op == OP_STORE);
        // An ack in the final wait cycle still wins over the timeout.
        if (mem_ack) begin
          next_state = (cmd_q.op == OP_LOAD) ? LOAD_MDR : DONE;
        end else if (timer_expired) begin
          next_state = DONE;
          err_next   = 1'b1;
        end
      end
      LOAD_MDR: begin
        MDRin      = !clr;
        readMDR    = !clr;
        next_state = XFER;
      end
      XFER: begin
        if (!clr) begin
          if (cmd_q.op == OP_LOAD) begin
            enc_out = enc_select(REG_MDR);
          end else begin
            enc_out = enc_select(cmd_q.src);
          end
          if (cmd_q.op == OP_STORE) begin
            MDRin = 1'b1;
          end else begin
            case (cmd_q.dst)
              REG_R0:  R0in  = 1'b1;
              REG_R1:  R1in  = 1'b1;
              REG_MDR: MDRin = 1'b1;
              default: R0in  = 1'b0;
            endcase
          end
        end
        next_state = (cmd_q.op == OP_STORE) ? MEM_WAIT : DONE;
      end
      DONE: begin
        done       = !clr;
        err        = !clr && err_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
